train_dispatch_gen: RTL and testbench
=====================================

// Module: train_dispatch_gen
// PURPOSE
//  Stimulus-side counterpart of the station-stack checker: consumes a frame of
//  push/pop operations on a single dead-end siding and emits the resulting
//  departure order as a frame on the checker's input protocol (N, then N car IDs).
//  Sits upstream of the checker. Serves as a frame source and as a golden model.
// PARAMETERS
//  MAX_CARS  10  max cars per frame; also the stack and departure-queue depth
//  CAR_W      4  width of the car ID and count fields; must hold MAX_CARS
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input beat valid; a frame is contiguous
//  data       in   CAR_W  beat 0: N (car count); beats 1..2N: data[0]=1 push, 0 pop
//  out_valid  out  1      output beat valid
//  out_data   out  CAR_W  beat 0: N; beats 1..N: departing car IDs in order
//  err        out  1      qualified by out_valid; 1 = illegal frame
// BEHAVIOUR
//  - Reset: async, active-low. out_valid=0, out_data=0, err=0, FSM=IDLE.
//    Stack, queue and counters are cleared. Reset mid-frame discards the frame.
//  - Cars arrive in order 1..N. A push moves the next arriving car onto the stack.
//    A pop appends the stack top to the departure queue.
//  - FSM IDLE->LOAD: on in_valid in IDLE, latch N=data and clear the push and op counters.
//    * N==0 or N>MAX_CARS: go to ERR. Upstream sends no op beats for such a frame.
//  - LOAD consumes exactly 2N op beats, one per cycle while in_valid=1.
//    * Pop with the stack empty -> error.
//    * Push after N pushes -> error.
//    * After the first error, set a sticky error flag. Keep consuming to 2N beats,
//      but leave the stack and queue unchanged.
//    * 2N beats with no error imply N pushes and N pops, so the stack ends empty.
//    * in_valid=0 in LOAD before beat 2N: abort to IDLE. No output, no err.
//  - LOAD->OUT or ERR: on the cycle after the 2N-th beat is registered,
//    go to ERR if the error flag is set, else to OUT.
//  - OUT streams N+1 consecutive cycles with out_valid=1 and err=0:
//    out_data = N, then queue[0..N-1]. Then go to IDLE with out_valid=0, out_data=0.
//  - ERR: one cycle with out_valid=1, err=1, out_data=0, then IDLE.
//  - Latency: the first output beat appears exactly 1 cycle after the last op beat.
//    For a bad N, it appears 1 cycle after the header beat.
//  - in_valid while in OUT or ERR is ignored. Upstream waits for out_valid to fall.
//    A new frame header is accepted in the cycle after the last out_valid beat.
//  - All outputs are registered. Counter arithmetic is CAR_W+1 bits for 2N,
//    so 2*MAX_CARS does not wrap.
//  - Stack pointer range is 0..MAX_CARS. Push at full cannot occur without
//    first tripping the push>N error.
// STRUCTURE
//  - Shared package train_pkg: MAX_CARS, CAR_W, and the FSM state encoding
//    {IDLE, LOAD, OUT, ERR}. The checker uses the same package.
//  - Sub-module train_stack: depth MAX_CARS LIFO, CAR_W wide.
//    Ports: push, pop, din, top, empty, full. Registers reset asynchronously.
//  - Top level holds the FSM, the counters, the departure queue
//    (MAX_CARS x CAR_W registers with a write index) and the output registers.
// TESTING
//  1 N=3, ops P,P,P,O,O,O -> out 3,3,2,1; err=0; first out beat 1 cycle after beat 6.
//  2 N=3, ops P,O,P,O,P,O -> out 3,1,2,3.
//  3 N=3, ops P,P,O,O,O,P (pop on empty at beat 5) -> single beat out_valid=1, err=1, out_data=0.
//  4 N=10, ten P then ten O -> out 10,10,9,...,1 (stack full boundary); N=11 -> immediate err beat.
//  5 Abort: drop in_valid after 3 op beats -> no out_valid. The next valid frame (case 2) is correct.
//  6 Reset mid-OUT after 2 beats -> outputs 0 immediately; a fresh frame (case 1) is correct.
//    Back-to-back frames: second header in the cycle after the last out beat is accepted.

Source files
------------

// File: rtl/train_pkg.sv
// train_pkg: shared sizing and FSM encoding for the siding
// dispatch generator and the station-stack checker.
package train_pkg;

   localparam int MAX_CARS = 10;
   localparam int CAR_W    = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      OUT  = 2'd2,
      ERR  = 2'd3
   } state_t;

endpackage

// File: rtl/train_dispatch_gen_if.sv
// train_dispatch_gen_if: frame-in / frame-out beat bus.
// master drives in_valid/data, slave drives out_valid/out_data/err.
interface train_dispatch_gen_if #(
   parameter int CAR_W = train_pkg::CAR_W
);

   logic             in_valid;
   logic [CAR_W-1:0] data;
   logic             out_valid;
   logic [CAR_W-1:0] out_data;
   logic             err;

   modport master (
      output in_valid, data,
      input  out_valid, out_data, err
   );

   modport slave (
      input  in_valid, data,
      output out_valid, out_data, err
   );

endinterface

// File: rtl/train_stack.sv
// train_stack: DEPTH-entry LIFO for the dead-end siding.
// Ports: clr/push/pop, din; top (0 when empty), empty, full.
module train_stack
   import train_pkg::*;
#(
   parameter int DEPTH = MAX_CARS,
   parameter int W     = CAR_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] FULL_P = PW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] sp;
   logic [PW-1:0] sp_m1;

   assign sp_m1 = sp - 1'b1;
   assign empty = (sp == '0);
   assign full  = (sp == FULL_P);
   assign top   = empty ? '0 : mem[sp_m1[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clr) begin
         sp <= '0;
      end else if (push && !full) begin
         mem[sp[AW-1:0]] <= din;
         sp <= sp + 1'b1;
      end else if (pop && !empty) begin
         sp <= sp_m1;
      end
   end

endmodule

// File: rtl/train_dispatch_gen.sv
// train_dispatch_gen: turns a push/pop frame into a departure frame.
// Ports: clk, rst_n, bus (slave: in_valid/data in; out_valid/out_data/err out).
module train_dispatch_gen
   import train_pkg::*;
#(
   parameter int MAX_CARS = train_pkg::MAX_CARS,
   parameter int CAR_W    = train_pkg::CAR_W
) (
   input logic                 clk,
   input logic                 rst_n,
   train_dispatch_gen_if.slave bus
);

   localparam int AW = (MAX_CARS > 1) ? $clog2(MAX_CARS) : 1;
   localparam int CW = CAR_W + 1;
   localparam logic [CW-1:0] MAX_C = CW'(MAX_CARS);

   state_t           state, state_d;
   logic [CAR_W-1:0] n_q, n_d;
   logic [CW-1:0]    push_cnt, push_d;
   logic [CW-1:0]    op_cnt, op_d;
   logic [CW-1:0]    wr_idx, wr_d;
   logic [CW-1:0]    rd_idx, rd_d;
   logic             errf, errf_d;
   logic [CAR_W-1:0] q [MAX_CARS];

   logic             ov_q, ov_d;
   logic             err_q, err_d;
   logic [CAR_W-1:0] od_q, od_d;

   logic             stk_clr, stk_push, stk_pop;
   logic [CAR_W-1:0] stk_din, stk_top;
   logic             stk_empty, stk_full;

   logic             is_push, bad_op, bad_n, take;
   logic [CW-1:0]    two_n;

   train_stack #(
      .DEPTH (MAX_CARS),
      .W     (CAR_W)
   ) u_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (stk_clr),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (stk_din),
      .top   (stk_top),
      .empty (stk_empty),
      .full  (stk_full)
   );

   assign two_n   = {n_q, 1'b0};
   assign is_push = bus.data[0];
   assign bad_n   = (bus.data == '0) ||
                    ({1'b0, bus.data} > MAX_C);
   // full can only coincide with push_cnt >= N; kept as a guard
   assign bad_op  = is_push ?
                    ((push_cnt >= {1'b0, n_q}) || stk_full) :
                    stk_empty;
   // after the first bad beat the siding is frozen
   assign take     = (state == LOAD) && bus.in_valid &&
                     !errf && !bad_op;
   assign stk_push = take && is_push;
   assign stk_pop  = take && !is_push;
   assign stk_din  = push_cnt[CAR_W-1:0] + 1'b1;
   assign stk_clr  = (state == IDLE) && bus.in_valid;

   assign bus.out_valid = ov_q;
   assign bus.out_data  = od_q;
   assign bus.err       = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      n_d     = n_q;
      push_d  = push_cnt;
      op_d    = op_cnt;
      wr_d    = wr_idx;
      rd_d    = rd_idx;
      errf_d  = errf;
      ov_d    = 1'b0;
      od_d    = '0;
      err_d   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.in_valid) begin
               n_d    = bus.data;
               push_d = '0;
               op_d   = '0;
               wr_d   = '0;
               rd_d   = '0;
               errf_d = 1'b0;
               if (bad_n) begin
                  state_d = ERR;
                  ov_d    = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (!bus.in_valid) begin
               state_d = IDLE;
            end else begin
               op_d   = op_cnt + 1'b1;
               errf_d = errf | bad_op;
               if (stk_push) push_d = push_cnt + 1'b1;
               if (stk_pop)  wr_d   = wr_idx + 1'b1;
               // header beat of the result leaves with the last op
               if (op_d == two_n) begin
                  ov_d = 1'b1;
                  if (errf_d) begin
                     state_d = ERR;
                     err_d   = 1'b1;
                  end else begin
                     state_d = OUT;
                     od_d    = n_q;
                  end
               end
            end
         end
         OUT: begin
            if (rd_idx < {1'b0, n_q}) begin
               ov_d = 1'b1;
               od_d = q[rd_idx[AW-1:0]];
               rd_d = rd_idx + 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         ERR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q      <= '0;
         push_cnt <= '0;
         op_cnt   <= '0;
         wr_idx   <= '0;
         rd_idx   <= '0;
         errf     <= 1'b0;
         ov_q     <= 1'b0;
         od_q     <= '0;
         err_q    <= 1'b0;
      end else begin
         n_q      <= n_d;
         push_cnt <= push_d;
         op_cnt   <= op_d;
         wr_idx   <= wr_d;
         rd_idx   <= rd_d;
         errf     <= errf_d;
         ov_q     <= ov_d;
         od_q     <= od_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_CARS; i++) begin
            q[i] <= '0;
         end
      end else if (stk_pop) begin
         q[wr_idx[AW-1:0]] <= stk_top;
      end
   end

endmodule

// File: tb/tb_train_dispatch_gen.sv
// tb_train_dispatch_gen: directed and random frames checked
// against a queue-based model of the dead-end siding.
module tb_train_dispatch_gen;

   localparam int CW   = 4;
   localparam int MAXC = 10;

   typedef struct {
      int            cyc;
      logic          err;
      logic [CW-1:0] d;
   } beat_t;

   logic  clk    = 1'b0;
   logic  rst_n  = 1'b1;
   int    cyc    = 0;
   int    checks = 0;
   int    errors = 0;
   int    last_cyc;
   bit    ops_arr [64];
   beat_t mon_q[$];
   int    exp_q[$];
   bit    exp_err;

   train_dispatch_gen_if #(.CAR_W(CW)) bus ();

   train_dispatch_gen #(
      .MAX_CARS (MAXC),
      .CAR_W    (CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.out_valid === 1'b1)
         mon_q.push_back('{cyc, bus.err, bus.out_data});
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, exp);
         end
   endtask

   task automatic set_ops(input string s);
      for (int i = 0; i < s.len(); i++)
         ops_arr[i] = (s[i] == "P");
   endtask

   task automatic gen_ops(input int n, input bit legal);
      int left;
      int depth;
      left  = n;
      depth = 0;
      for (int i = 0; i < 2 * n; i++) begin
         if (!legal) begin
            ops_arr[i] = 1'($urandom);
         end else if (left > 0 &&
                      (depth == 0 || $urandom_range(1) == 1)) begin
            ops_arr[i] = 1'b1;
            left--;
            depth++;
         end else begin
            ops_arr[i] = 1'b0;
            depth--;
         end
      end
   endtask

   // Cars 1..n arrive in order; the siding is a plain LIFO.
   task automatic model(input int n, input int nops);
      int stk[$];
      int next_car;
      exp_q.delete();
      exp_err  = (n < 1 || n > MAXC);
      next_car = 1;
      if (!exp_err) begin
         for (int i = 0; i < nops; i++) begin
            if (ops_arr[i]) begin
               if (next_car > n) begin
                  exp_err = 1'b1;
                  break;
               end
               stk.push_back(next_car);
               next_car++;
            end else begin
               if (stk.size() == 0) begin
                  exp_err = 1'b1;
                  break;
               end
               exp_q.push_back(stk.pop_back());
            end
         end
      end
      if (exp_err) begin
         exp_q.delete();
         exp_q.push_back(0);
      end else begin
         exp_q.push_front(n);
      end
   endtask

   // Called at posedge+1; returns at posedge+1, post cycles
   // after the cycle in which in_valid drops.
   task automatic run_frame(input int n, input int nsend,
                            input int post);
      bus.in_valid = 1'b1;
      bus.data     = CW'(n);
      last_cyc     = cyc;
      for (int i = 0; i < nsend; i++) begin
         @(posedge clk);
         #1;
         bus.data = {3'($urandom), ops_arr[i]};
         last_cyc = cyc;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.data     = '0;
      repeat (post) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_frame(input int n, input int nops,
                              input string name);
      beat_t b;
      model(n, nops);
      chk({name, " nbeats"}, mon_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (mon_q.size() > 0) begin
            b = mon_q.pop_front();
            chk($sformatf("%s b%0d cyc", name, i),
                b.cyc, last_cyc + 1 + i);
            chk($sformatf("%s b%0d err", name, i),
                b.err, exp_err);
            chk($sformatf("%s b%0d data", name, i),
                b.d, exp_q[i]);
         end
      end
      mon_q.delete();
   endtask

   initial begin
      int n;
      int mode;
      bus.in_valid = 1'b0;
      bus.data     = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst out_data", bus.out_data, 0);
      chk("rst err", bus.err, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      set_ops("PPPOOO");
      run_frame(3, 6, 14);
      check_frame(3, 6, "c1");

      set_ops("POPOPO");
      run_frame(3, 6, 14);
      check_frame(3, 6, "c2");

      set_ops("PPOOOP");
      run_frame(3, 6, 14);
      check_frame(3, 6, "c3");

      set_ops("PPPPPPPPPPOOOOOOOOOO");
      run_frame(10, 20, 14);
      check_frame(10, 20, "c4 n10");

      run_frame(11, 0, 14);
      check_frame(11, 0, "c4 n11");

      run_frame(0, 0, 14);
      check_frame(0, 0, "n0");

      set_ops("POPOPO");
      run_frame(3, 3, 14);
      chk("c5 abort nbeats", mon_q.size(), 0);
      mon_q.delete();
      run_frame(3, 6, 14);
      check_frame(3, 6, "c5 next");

      set_ops("PPPOOO");
      run_frame(3, 6, 1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("c6 beats before rst", mon_q.size(), 2);
      chk("c6 rst out_valid", bus.out_valid, 0);
      chk("c6 rst out_data", bus.out_data, 0);
      chk("c6 rst err", bus.err, 0);
      mon_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_frame(3, 6, 14);
      check_frame(3, 6, "c6 fresh");

      set_ops("POPOPO");
      run_frame(3, 6, 4);
      check_frame(3, 6, "bb1");
      set_ops("PPPOOO");
      run_frame(3, 6, 14);
      check_frame(3, 6, "bb2");

      run_frame(12, 0, 1);
      check_frame(12, 0, "bb err");
      set_ops("PPOPOO");
      run_frame(3, 6, 14);
      check_frame(3, 6, "bb after err");

      for (int f = 0; f < 40; f++) begin
         mode = $urandom_range(3);
         if (mode == 3) begin
            n = ($urandom_range(3) == 0) ? 0 :
                $urandom_range(15, 11);
            run_frame(n, 0, $urandom_range(6, 1));
            check_frame(n, 0, $sformatf("rnd%0d", f));
         end else begin
            n = $urandom_range(MAXC, 1);
            gen_ops(n, mode != 0);
            run_frame(n, 2 * n, $urandom_range(14, n + 1));
            check_frame(n, 2 * n, $sformatf("rnd%0d", f));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
